// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD down-counter with prescaled tick.
// Loads a clamped BCD preset, decrements once per PRESCALE cycles while
// running, and pulses Done_Out for one cycle when the count reaches zero.
// Optional build macro: AUTO_RELOAD_EN turns the one-shot into a periodic
// timer that reloads the last preset on the tick after reaching zero.
module bcd_countdown_timer #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 10
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Load_In,
  input  logic [4*DIGITS-1:0]   Load_Value_In,
  input  logic                  Start_Stopb_In,
  output logic [4*DIGITS-1:0]   Count_Out,
  output logic                  Running_Out,
  output logic                  Done_Out
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    clamp_val, dec_val;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            running_q;
  logic [DIGITS-1:0] borrow;
  logic            count_zero, dec_zero, tick;

`ifdef AUTO_RELOAD_EN
  logic [W-1:0]    reload_q, reload_d;
`endif

  // Per-digit preset clamp and ripple-borrow decrement
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] cur, ld;
    assign cur = count_q[4*g +: 4];
    assign ld  = Load_Value_In[4*g +: 4];
    assign clamp_val[4*g +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    if (g == 0) begin : g_lsd
      assign borrow[g] = 1'b1;
    end else begin : g_upper
      assign borrow[g] = borrow[g-1] && (count_q[4*(g-1) +: 4] == 4'd0);
    end
    assign dec_val[4*g +: 4] = !borrow[g]    ? cur :
                               (cur == 4'd0) ? 4'd9 : cur - 4'd1;
  end

  assign count_zero = (count_q == '0);
  assign dec_zero   = (dec_val == '0);
  // Prescaler keeps running in RUN; the terminal phase is the tick
  assign tick       = (state_q == RUN) && (presc_q == PS_LAST);

  // Next-state, count, prescaler and done-pulse decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (Load_In) begin
      count_d = clamp_val;
      presc_d = '0;
      state_d = IDLE;
`ifdef AUTO_RELOAD_EN
      reload_d = clamp_val;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (Start_Stopb_In && !count_zero) state_d = RUN;
        RUN: begin
          // The edge that sees Start low still advances the prescaler and
          // applies a due tick, so a resume continues the same tick phase.
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
`ifdef AUTO_RELOAD_EN
            if (count_zero) begin
              count_d = reload_q;
            end else begin
              count_d = dec_val;
              done_d  = dec_zero;
            end
`else
            count_d = dec_val;
            done_d  = dec_zero;
            if (dec_zero) state_d = DONE;
`endif
          end
          if (!Start_Stopb_In) state_d = IDLE;
        end
        DONE: if (!Start_Stopb_In) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
    end
  end

`ifdef AUTO_RELOAD_EN
  // Reload register holding the last clamped preset
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) reload_q <= '0;
    else          reload_q <= reload_d;
  end
`endif

  assign Count_Out   = count_q;
  assign Running_Out = running_q;
  assign Done_Out    = done_q;

endmodule
